calc_port_scheduler: RTL and testbench
======================================

Name: calc_port_scheduler

Overview:
- Four-requester front end that shares one arithmetic unit between ports 1-4.
- Uses the same two-cycle request protocol as the calc1 datapath:
  - cycle 1: command plus operand 1;
  - cycle 2: operand 2.
- Captures each port's request and arbitrates round-robin for the single shared ALU.
- Returns each result on the originating port's response/data pair.

Parameters:
- DATA_W, 32, operand/result width.
- CMD_W, 4, command width.

Ports:
- c_clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- reqN_cmd_in (N=1..4)  input  [0:CMD_W-1]  command, non-zero = new request.
- reqN_data_in (N=1..4)  input  [0:DATA_W-1]  operand 1 in command cycle, operand 2 in the next cycle.
- out_respN (N=1..4)  output  [0:1]  response code, valid for one cycle.
- out_dataN (N=1..4)  output  [0:DATA_W-1]  result, valid with out_respN.

Behaviour:
- Reset: all out_respN=0 and out_dataN=0; every port FSM in IDLE; round-robin pointer at port 1; ALU result register cleared. Reset asserted mid-operation discards all captured and pending requests; no response is produced for them after release.
- Commands:
  - 0 = nop; 1 = add; 2 = sub; 5 = shift left; 6 = shift right.
  - Any other non-zero code is invalid.
- Responses:
  - 0 = none; 1 = success; 2 = overflow/underflow/invalid.
  - 3 is never driven.
- Per-port FSM:
  - IDLE: non-zero cmd captures cmd and operand 1 -> OP2.
  - OP2: captures data_in as operand 2 unconditionally, cmd ignored -> PEND.
  - PEND: waits for grant; on grant -> WAIT.
  - WAIT: ALU result registered this cycle -> RESP.
  - RESP: out_respN/out_dataN driven for exactly one cycle -> IDLE.
  - Non-zero cmd while not IDLE is silently dropped.
  - A new command is accepted in the cycle after RESP, not during RESP.
- Arbiter:
  - At most one grant per cycle among PEND ports.
  - Round-robin starting at the pointer; after a grant the pointer moves to granted port +1, wrapping 4 -> 1.
  - No PEND ports: no grant, pointer unchanged.
  - A port entering PEND in the same cycle as a grant is eligible from the next cycle.
- Latency: cmd in cycle T, op2 in T+1, grant in T+2 at the earliest, response visible in T+3. Each cycle of contention adds one cycle.
- Arithmetic, unsigned DATA_W:
  - add: carry-out -> resp 2, data 0.
  - sub: op1<op2 -> resp 2, data 0.
  - shl/shr: shift amount = op2[DATA_W-5:DATA_W-1] (low 5 bits), zero fill, always resp 1.
  - invalid cmd: resp 2, data 0.
- Outputs of ports not in RESP are held at 0.

Optional Feature:
- CALC_OP_CNT_EN
  - Defined: adds output op_count [0:15], which counts responses with resp=1 across all ports. Saturates at 16'hFFFF and resets to 0.
  - Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Package calc_pkg holds:
  - CMD_NOP/ADD/SUB/SHL/SHR encodings;
  - RESP_NONE/OK/ERR encodings;
  - port FSM state enum;
  - DATA_W/CMD_W defaults.
- Sub-module calc_alu: combinational, takes cmd/op1/op2 and returns result and resp code. The scheduler registers its output.
- Per-port FSM is generated four times inside calc_port_scheduler.

Test Plan:
- Single add: port1 cmd=1 data=5, next cycle data=7 -> out_resp1=1, out_data1=12 in cycle T+3, zero in T+4.
- Overflow and underflow:
  - port2 add FFFFFFFF+1 -> resp2=2, data2=0;
  - port3 sub 3-5 -> resp3=2, data3=0.
- Full contention: all four ports issue add 1+1 in the same cycle after reset -> responses on ports 1,2,3,4 in cycles T+3, T+4, T+5, T+6. A repeat round then starts at port 1 again.
- Busy drop and invalid command:
  - port4 cmd=1 (data 2, 3), then cmd=2 during OP2 -> only resp4=1, data4=5; the second command is never answered.
  - Separately, port1 cmd=9 -> resp1=2, data1=0.
- Shifts: port1 shl 0x00000001 by 0x00000024 (effective 4) -> resp 1, data 0x10; port2 shr 0x80000000 by 31 -> resp 1, data 1.
- Reset mid-operation: reset low while ports 1 and 2 are in PEND -> all outputs 0 immediately, no responses after release; a fresh port2 request is answered at T+3.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared encodings, port FSM state type and width defaults for the calc port scheduler.
package calc_pkg;

  localparam int unsigned DefDataW = 32;
  localparam int unsigned DefCmdW  = 4;
  localparam int unsigned NumPorts = 4;

  localparam int unsigned CMD_NOP = 0;
  localparam int unsigned CMD_ADD = 1;
  localparam int unsigned CMD_SUB = 2;
  localparam int unsigned CMD_SHL = 5;
  localparam int unsigned CMD_SHR = 6;

  localparam logic [1:0] RESP_NONE = 2'd0;
  localparam logic [1:0] RESP_OK   = 2'd1;
  localparam logic [1:0] RESP_ERR  = 2'd2;

  // The grant cycle is the port's wait step: the shared ALU result is
  // registered on the grant edge, so PEND moves straight to RESP.
  typedef enum logic [1:0] {StIdle, StOp2, StPend, StResp} port_state_e;

endpackage

// File: rtl/calc_alu.sv
// Combinational unsigned ALU shared by all scheduler ports; returns result and response code.
module calc_alu
  import calc_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned CMD_W  = DefCmdW
) (
  input  logic [CMD_W-1:0]  cmd_i,
  input  logic [DATA_W-1:0] op1_i,
  input  logic [DATA_W-1:0] op2_i,
  output logic [DATA_W-1:0] res_o,
  output logic [1:0]        resp_o
);

  logic [DATA_W:0] sum;
  logic [4:0]      shamt;

  assign sum   = {1'b0, op1_i} + {1'b0, op2_i};
  assign shamt = op2_i[4:0];

  always_comb begin
    res_o  = '0;
    resp_o = RESP_ERR;
    case (cmd_i)
      CMD_W'(CMD_ADD): begin
        if (!sum[DATA_W]) begin
          res_o  = sum[DATA_W-1:0];
          resp_o = RESP_OK;
        end
      end
      CMD_W'(CMD_SUB): begin
        if (op1_i >= op2_i) begin
          res_o  = op1_i - op2_i;
          resp_o = RESP_OK;
        end
      end
      CMD_W'(CMD_SHL): begin
        res_o  = op1_i << shamt;
        resp_o = RESP_OK;
      end
      CMD_W'(CMD_SHR): begin
        res_o  = op1_i >> shamt;
        resp_o = RESP_OK;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/calc_port_scheduler.sv
// Four-port two-cycle request front end sharing one ALU via a round-robin arbiter.
// Optional CALC_OP_CNT_EN adds a saturating count of successful responses (op_count).
module calc_port_scheduler
  import calc_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned CMD_W  = DefCmdW
) (
`ifdef CALC_OP_CNT_EN
  output logic [0:15]       op_count,
`endif
  input  logic              c_clk,
  input  logic              reset,
  input  logic [0:CMD_W-1]  req1_cmd_in,
  input  logic [0:DATA_W-1] req1_data_in,
  input  logic [0:CMD_W-1]  req2_cmd_in,
  input  logic [0:DATA_W-1] req2_data_in,
  input  logic [0:CMD_W-1]  req3_cmd_in,
  input  logic [0:DATA_W-1] req3_data_in,
  input  logic [0:CMD_W-1]  req4_cmd_in,
  input  logic [0:DATA_W-1] req4_data_in,
  output logic [0:1]        out_resp1,
  output logic [0:DATA_W-1] out_data1,
  output logic [0:1]        out_resp2,
  output logic [0:DATA_W-1] out_data2,
  output logic [0:1]        out_resp3,
  output logic [0:DATA_W-1] out_data3,
  output logic [0:1]        out_resp4,
  output logic [0:DATA_W-1] out_data4
);

  logic [CMD_W-1:0]  cmd_in   [NumPorts];
  logic [DATA_W-1:0] data_in  [NumPorts];
  logic [1:0]        resp_out [NumPorts];
  logic [DATA_W-1:0] data_out [NumPorts];
  logic [CMD_W-1:0]  cmd_arr  [NumPorts];
  logic [DATA_W-1:0] op1_arr  [NumPorts];
  logic [DATA_W-1:0] op2_arr  [NumPorts];

  logic [NumPorts-1:0] pend, gnt, in_resp;
  logic [1:0]          rr_q, rr_d, gnt_idx, cand;
  logic                gnt_any;
  logic [DATA_W-1:0]   alu_res, alu_res_q;
  logic [1:0]          alu_resp, alu_resp_q;

  assign cmd_in[0]  = req1_cmd_in;
  assign cmd_in[1]  = req2_cmd_in;
  assign cmd_in[2]  = req3_cmd_in;
  assign cmd_in[3]  = req4_cmd_in;
  assign data_in[0] = req1_data_in;
  assign data_in[1] = req2_data_in;
  assign data_in[2] = req3_data_in;
  assign data_in[3] = req4_data_in;

  assign out_resp1 = resp_out[0];
  assign out_data1 = data_out[0];
  assign out_resp2 = resp_out[1];
  assign out_data2 = data_out[1];
  assign out_resp3 = resp_out[2];
  assign out_data3 = data_out[2];
  assign out_resp4 = resp_out[3];
  assign out_data4 = data_out[3];

  for (genvar p = 0; p < NumPorts; p++) begin : g_port
    port_state_e       st_q, st_d;
    logic [CMD_W-1:0]  cmd_q, cmd_d;
    logic [DATA_W-1:0] op1_q, op1_d, op2_q, op2_d;
    logic [1:0]        resp_p;
    logic [DATA_W-1:0] data_p;

    always_ff @(posedge c_clk or negedge reset) begin
      if (!reset) begin
        st_q  <= StIdle;
        cmd_q <= '0;
        op1_q <= '0;
        op2_q <= '0;
      end else begin
        st_q  <= st_d;
        cmd_q <= cmd_d;
        op1_q <= op1_d;
        op2_q <= op2_d;
      end
    end

    always_comb begin
      st_d  = st_q;
      cmd_d = cmd_q;
      op1_d = op1_q;
      op2_d = op2_q;
      unique case (st_q)
        StIdle: begin
          if (cmd_in[p] != CMD_W'(CMD_NOP)) begin
            cmd_d = cmd_in[p];
            op1_d = data_in[p];
            st_d  = StOp2;
          end
        end
        StOp2: begin
          op2_d = data_in[p];
          st_d  = StPend;
        end
        StPend:  if (gnt[p]) st_d = StResp;
        StResp:  st_d = StIdle;
        default: st_d = StIdle;
      endcase
    end

    always_comb begin
      resp_p = RESP_NONE;
      data_p = '0;
      if (st_q == StResp) begin
        resp_p = alu_resp_q;
        data_p = alu_res_q;
      end
    end

    assign pend[p]     = (st_q == StPend);
    assign in_resp[p]  = (st_q == StResp);
    assign cmd_arr[p]  = cmd_q;
    assign op1_arr[p]  = op1_q;
    assign op2_arr[p]  = op2_q;
    assign resp_out[p] = resp_p;
    assign data_out[p] = data_p;
  end

  // Scan from the pointer; the first PEND port wins and the pointer moves past it.
  always_comb begin
    gnt     = '0;
    gnt_any = 1'b0;
    gnt_idx = rr_q;
    rr_d    = rr_q;
    cand    = rr_q;
    for (int i = 0; i < NumPorts; i++) begin
      cand = rr_q + 2'(i);
      if (!gnt_any && pend[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
    if (gnt_any) begin
      gnt[gnt_idx] = 1'b1;
      rr_d         = gnt_idx + 2'd1;
    end
  end

  calc_alu #(
    .DATA_W(DATA_W),
    .CMD_W (CMD_W)
  ) u_alu (
    .cmd_i (cmd_arr[gnt_idx]),
    .op1_i (op1_arr[gnt_idx]),
    .op2_i (op2_arr[gnt_idx]),
    .res_o (alu_res),
    .resp_o(alu_resp)
  );

  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      rr_q       <= '0;
      alu_res_q  <= '0;
      alu_resp_q <= RESP_NONE;
    end else begin
      rr_q <= rr_d;
      if (gnt_any) begin
        alu_res_q  <= alu_res;
        alu_resp_q <= alu_resp;
      end
    end
  end

`ifdef CALC_OP_CNT_EN
  logic [15:0] op_cnt_q;
  logic        ok_fire;

  assign ok_fire = (|in_resp) && (alu_resp_q == RESP_OK);

  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      op_cnt_q <= '0;
    end else if (ok_fire && (op_cnt_q != 16'hFFFF)) begin
      op_cnt_q <= op_cnt_q + 16'd1;
    end
  end

  assign op_count = op_cnt_q;
`else
  logic unused_in_resp;
  assign unused_in_resp = ^in_resp;
`endif

endmodule

// File: tb/tb_calc_port_scheduler.sv
// Self-checking bench for calc_port_scheduler: directed vectors plus random traffic vs a cycle-level model.
module tb_calc_port_scheduler;

  logic        c_clk = 1'b0;
  logic        reset;
  logic [3:0]  cmd_v  [4];
  logic [31:0] dat_v  [4];
  logic [1:0]  o_resp [4];
  logic [31:0] o_data [4];
  logic [1:0]  s_resp [4];
  logic [31:0] s_data [4];
`ifdef CALC_OP_CNT_EN
  logic [15:0] op_count;
`endif

  always #5 c_clk = ~c_clk;

  calc_port_scheduler #(
    .DATA_W(32),
    .CMD_W (4)
  ) dut (
`ifdef CALC_OP_CNT_EN
    .op_count    (op_count),
`endif
    .c_clk       (c_clk),
    .reset       (reset),
    .req1_cmd_in (cmd_v[0]),
    .req1_data_in(dat_v[0]),
    .req2_cmd_in (cmd_v[1]),
    .req2_data_in(dat_v[1]),
    .req3_cmd_in (cmd_v[2]),
    .req3_data_in(dat_v[2]),
    .req4_cmd_in (cmd_v[3]),
    .req4_data_in(dat_v[3]),
    .out_resp1   (o_resp[0]),
    .out_data1   (o_data[0]),
    .out_resp2   (o_resp[1]),
    .out_data2   (o_data[1]),
    .out_resp3   (o_resp[2]),
    .out_data3   (o_data[2]),
    .out_resp4   (o_resp[3]),
    .out_data4   (o_data[3])
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Transaction-level model: each request becomes grant-eligible two cycles after its
  // command, answers one cycle after its grant, and frees the port the cycle after that.
  bit              m_pend     [4];
  int              m_ready    [4];
  int              m_free     [4];
  int              m_op2_cyc  [4];
  int              m_resp_cyc [4];
  int              m_cmd      [4];
  longint unsigned m_op1      [4];
  longint unsigned m_op2      [4];
  logic [1:0]      m_er       [4];
  logic [31:0]     m_ed       [4];
  int              m_ptr;

  typedef struct {
    int          port;
    logic [3:0]  cmd;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [1:0]  resp;
    logic [31:0] data;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  function automatic void alu_ref(input int c, input longint unsigned a, input longint unsigned b,
                                  output logic [1:0] r, output logic [31:0] d);
    longint unsigned t;
    r = 2'd2;
    d = 32'd0;
    case (c)
      1: begin
        t = a + b;
        if (t <= 64'hFFFF_FFFF) begin
          r = 2'd1;
          d = t[31:0];
        end
      end
      2: begin
        if (a >= b) begin
          t = a - b;
          r = 2'd1;
          d = t[31:0];
        end
      end
      5: begin
        t = a << (b % 32);
        r = 2'd1;
        d = t[31:0];
      end
      6: begin
        t = a >> (b % 32);
        r = 2'd1;
        d = t[31:0];
      end
      default: ;
    endcase
  endfunction

  task automatic model_reset();
    for (int p = 0; p < 4; p++) begin
      m_pend[p]     = 1'b0;
      m_free[p]     = cyc;
      m_op2_cyc[p]  = -1;
      m_resp_cyc[p] = -1;
    end
    m_ptr = 0;
  endtask

  task automatic model_advance();
    int g;
    for (int i = 0; i < 4; i++) begin
      g = (m_ptr + i) % 4;
      if (m_pend[g] && cyc >= m_ready[g]) begin
        alu_ref(m_cmd[g], m_op1[g], m_op2[g], m_er[g], m_ed[g]);
        m_pend[g]     = 1'b0;
        m_resp_cyc[g] = cyc + 1;
        m_free[g]     = cyc + 2;
        m_ptr         = (g + 1) % 4;
        break;
      end
    end
    for (int p = 0; p < 4; p++) begin
      if (m_op2_cyc[p] == cyc) m_op2[p] = longint'(dat_v[p]);
      if (cmd_v[p] != 4'd0 && cyc >= m_free[p]) begin
        m_pend[p]    = 1'b1;
        m_cmd[p]     = int'(cmd_v[p]);
        m_op1[p]     = longint'(dat_v[p]);
        m_ready[p]   = cyc + 2;
        m_op2_cyc[p] = cyc + 1;
        m_free[p]    = 32'h7FFF_FFFF;
      end
    end
  endtask

  // Entered just after a rising edge with this cycle's inputs applied.
  task automatic step();
    logic [1:0]  er;
    logic [31:0] ed;
    #3;
    for (int p = 0; p < 4; p++) begin
      s_resp[p] = o_resp[p];
      s_data[p] = o_data[p];
      er = (m_resp_cyc[p] == cyc) ? m_er[p] : 2'd0;
      ed = (m_resp_cyc[p] == cyc) ? m_ed[p] : 32'd0;
      chk($sformatf("model_resp%0d", p + 1), 32'(s_resp[p]), 32'(er));
      chk($sformatf("model_data%0d", p + 1), s_data[p], ed);
    end
    model_advance();
    @(posedge c_clk);
    #1;
    cyc++;
    for (int p = 0; p < 4; p++) begin
      cmd_v[p] = 4'd0;
      dat_v[p] = 32'd0;
    end
  endtask

  task automatic chk_outs_zero(input string name);
    for (int p = 0; p < 4; p++) begin
      chk($sformatf("%s_resp%0d", name, p + 1), 32'(o_resp[p]), 32'd0);
      chk($sformatf("%s_data%0d", name, p + 1), o_data[p], 32'd0);
    end
  endtask

  initial begin
    tbl[0] = '{port: 0, cmd: 4'd1, op1: 32'd5,          op2: 32'd7,          resp: 2'd1, data: 32'd12};
    tbl[1] = '{port: 1, cmd: 4'd1, op1: 32'hFFFF_FFFF,  op2: 32'd1,          resp: 2'd2, data: 32'd0};
    tbl[2] = '{port: 2, cmd: 4'd2, op1: 32'd3,          op2: 32'd5,          resp: 2'd2, data: 32'd0};
    tbl[3] = '{port: 0, cmd: 4'd9, op1: 32'd4,          op2: 32'd4,          resp: 2'd2, data: 32'd0};
    tbl[4] = '{port: 0, cmd: 4'd5, op1: 32'd1,          op2: 32'h24,         resp: 2'd1, data: 32'h10};
    tbl[5] = '{port: 1, cmd: 4'd6, op1: 32'h8000_0000,  op2: 32'd31,         resp: 2'd1, data: 32'd1};
    tbl[6] = '{port: 3, cmd: 4'd2, op1: 32'd10,         op2: 32'd3,          resp: 2'd1, data: 32'd7};
    tbl[7] = '{port: 2, cmd: 4'd5, op1: 32'hF000_0000,  op2: 32'd4,          resp: 2'd1, data: 32'd0};
    tbl[8] = '{port: 3, cmd: 4'd15, op1: 32'd1,         op2: 32'd1,          resp: 2'd2, data: 32'd0};
    tbl[9] = '{port: 1, cmd: 4'd1, op1: 32'hFFFF_FFFE,  op2: 32'd1,          resp: 2'd1, data: 32'hFFFF_FFFF};

    reset = 1'b0;
    for (int p = 0; p < 4; p++) begin
      cmd_v[p] = 4'd0;
      dat_v[p] = 32'd0;
    end
    repeat (2) @(posedge c_clk);
    #1;
    chk_outs_zero("reset");
    reset = 1'b1;
    cyc   = 0;
    model_reset();

    // Full contention: responses on ports 1..4 in consecutive cycles.
    for (int p = 0; p < 4; p++) begin
      cmd_v[p] = 4'd1;
      dat_v[p] = 32'd1;
    end
    step();
    for (int p = 0; p < 4; p++) dat_v[p] = 32'd1;
    step();
    step();
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("cont_resp%0d", k + 1), 32'(s_resp[k]), 32'd1);
      chk($sformatf("cont_data%0d", k + 1), s_data[k], 32'd2);
    end
    // Repeat round: pointer wrapped back to port 1.
    for (int p = 0; p < 4; p++) begin
      cmd_v[p] = 4'd1;
      dat_v[p] = 32'd2;
    end
    step();
    for (int p = 0; p < 4; p++) dat_v[p] = 32'd3;
    step();
    step();
    step();
    chk("rep_first_resp1", 32'(s_resp[0]), 32'd1);
    chk("rep_first_data1", s_data[0], 32'd5);
    chk("rep_first_resp4", 32'(s_resp[3]), 32'd0);
    repeat (4) step();

    for (int k = 0; k < 10; k++) begin
      cmd_v[tbl[k].port] = tbl[k].cmd;
      dat_v[tbl[k].port] = tbl[k].op1;
      step();
      dat_v[tbl[k].port] = tbl[k].op2;
      step();
      step();
      step();
      chk($sformatf("vec%0d_resp", k), 32'(s_resp[tbl[k].port]), 32'(tbl[k].resp));
      chk($sformatf("vec%0d_data", k), s_data[tbl[k].port], tbl[k].data);
      step();
      chk($sformatf("vec%0d_after", k), 32'(s_resp[tbl[k].port]), 32'd0);
    end

    // Busy drop: a command arriving during OP2 is ignored.
    cmd_v[3] = 4'd1;
    dat_v[3] = 32'd2;
    step();
    cmd_v[3] = 4'd2;
    dat_v[3] = 32'd3;
    step();
    step();
    step();
    chk("drop_resp4", 32'(s_resp[3]), 32'd1);
    chk("drop_data4", s_data[3], 32'd5);
    repeat (6) step();

    // Reset while port 1 answers and port 2 is still pending.
    cmd_v[0] = 4'd1;
    dat_v[0] = 32'd4;
    cmd_v[1] = 4'd1;
    dat_v[1] = 32'd6;
    step();
    dat_v[0] = 32'd4;
    dat_v[1] = 32'd6;
    step();
    step();
    #1;
    chk("prereset_resp1", 32'(o_resp[0]), 32'd1);
    chk("prereset_data1", o_data[0], 32'd8);
    reset = 1'b0;
    #1;
    chk_outs_zero("midreset");
    @(posedge c_clk);
    @(posedge c_clk);
    #1;
    reset = 1'b1;
    cyc   = cyc + 3;
    model_reset();
    repeat (6) step();
    cmd_v[1] = 4'd1;
    dat_v[1] = 32'd10;
    step();
    dat_v[1] = 32'd20;
    step();
    step();
    step();
    chk("postreset_resp2", 32'(s_resp[1]), 32'd1);
    chk("postreset_data2", s_data[1], 32'd30);
    step();

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      for (int p = 0; p < 4; p++) begin
        if ($urandom_range(0, 2) == 0) begin
          case ($urandom_range(0, 7))
            0, 1:    cmd_v[p] = 4'd1;
            2, 3:    cmd_v[p] = 4'd2;
            4:       cmd_v[p] = 4'd5;
            5:       cmd_v[p] = 4'd6;
            default: cmd_v[p] = 4'($urandom_range(1, 15));
          endcase
        end
        if ($urandom_range(0, 3) == 0) dat_v[p] = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        else if ($urandom_range(0, 2) == 0) dat_v[p] = 32'($urandom_range(0, 40));
        else dat_v[p] = $urandom;
      end
      step();
    end
    repeat (10) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
